// File: rtl/board_engine.sv
// 4x4 sliding-tile board: holds exponent codes, executes moves a line per cycle,
// spawns tiles from a free-running LFSR and serves combinational tile reads.
// state | meaning
// INIT  | post-reset, arms the two opening spawns
// IDLE  | accepts cell loads and moves
// LINE  | slide/merge one line per cycle, 4 lines
// SPAWN | scan from lfsr-chosen cell for an empty one
// CHECK | evaluate game-over, then back to IDLE
module board_engine #(
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter logic [3:0]  WIN_CODE       = 4'd11,
  parameter logic [3:0]  FOUR_PROB_MASK = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  input  logic        load_en,
  input  logic [3:0]  load_id,
  input  logic [3:0]  load_code,
  input  logic [3:0]  BlockID,
  output logic [3:0]  BlockType,
  output logic        busy,
  output logic [15:0] score,
  output logic        win,
  output logic        game_over
);

  typedef enum logic [2:0] {INIT, IDLE, LINE, SPAWN, CHECK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  board_q [16];
  logic [3:0]  board_d [16];
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] score_q, score_d;
  logic        win_q, win_d;
  logic        game_over_q, game_over_d;
  logic [1:0]  dir_q, dir_d;
  logic [1:0]  line_q, line_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  scan_q, scan_d;
  logic        changed_q, changed_d;
  logic        init_more_q, init_more_d;

  logic [3:0]  ids [4];
  logic [3:0]  a [4];
  logic [3:0]  c [5];
  logic [3:0]  o [4];
  logic [2:0]  nc, no;
  logic        skip;
  logic [3:0]  res;
  logic [16:0] sum;
  logic [15:0] sc;
  logic        line_win, line_diff;
  logic        full, adj_eq;
  logic [3:0]  spawn_code;

  // Cell id of element k of a line, k = 0 sitting at the destination edge.
  function automatic logic [3:0] cell_id(input logic [1:0] dir, input logic [1:0] line,
                                         input logic [1:0] k);
    logic [1:0] rk;
    rk = 2'd3 - k;
    case (dir)
      2'd0:    cell_id = {rk, line};
      2'd1:    cell_id = {k, line};
      2'd2:    cell_id = {line, k};
      default: cell_id = {line, rk};
    endcase
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ids[k] = cell_id(dir_q, line_q, 2'(k));
      a[k]   = board_q[ids[k]];
    end
    for (int k = 0; k < 5; k++) c[k] = '0;
    nc = '0;
    for (int k = 0; k < 4; k++) begin
      if (a[k] != 4'd0) begin
        c[nc[1:0]] = a[k];
        nc = nc + 3'd1;
      end
    end
    for (int k = 0; k < 4; k++) o[k] = '0;
    no = '0;
    skip = 1'b0;
    res = '0;
    sum = '0;
    sc = score_q;
    line_win = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (c[k] != 4'd0 && c[k] == c[k+1]) begin
        res = (c[k] == 4'hF) ? 4'hF : c[k] + 4'd1;
        o[no[1:0]] = res;
        no = no + 3'd1;
        skip = 1'b1;
        sum = {1'b0, sc} + (17'd1 << res);
        sc = sum[16] ? 16'hFFFF : sum[15:0];
        if (res >= WIN_CODE) line_win = 1'b1;
      end else begin
        o[no[1:0]] = c[k];
        no = no + 3'd1;
      end
    end
    line_diff = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (o[k] != a[k]) line_diff = 1'b1;
    end
  end

  always_comb begin
    full = 1'b1;
    adj_eq = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (board_q[i] == 4'd0) full = 1'b0;
    end
    for (int r = 0; r < 4; r++) begin
      for (int col = 0; col < 3; col++) begin
        if (board_q[4*r+col] == board_q[4*r+col+1]) adj_eq = 1'b1;
      end
    end
    for (int i = 0; i < 12; i++) begin
      if (board_q[i] == board_q[i+4]) adj_eq = 1'b1;
    end
  end

  assign spawn_code = ((lfsr_q[7:4] & FOUR_PROB_MASK) == 4'd0) ? 4'd2 : 4'd1;

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    score_d     = score_q;
    win_d       = win_q;
    game_over_d = game_over_q;
    dir_d       = dir_q;
    line_d      = line_q;
    ptr_d       = ptr_q;
    scan_d      = scan_q;
    changed_d   = changed_q;
    init_more_d = init_more_q;
    case (state_q)
      INIT: begin
        ptr_d       = lfsr_q[3:0];
        scan_d      = '0;
        init_more_d = 1'b1;
        state_d     = SPAWN;
      end
      IDLE: begin
        if (load_en) begin
          board_d[load_id] = load_code;
        end else if (move_valid && !game_over_q) begin
          dir_d     = move_dir;
          changed_d = 1'b0;
          line_d    = '0;
          state_d   = LINE;
        end
      end
      LINE: begin
        for (int k = 0; k < 4; k++) board_d[ids[k]] = o[k];
        score_d = sc;
        if (line_win) win_d = 1'b1;
        if (line_diff) changed_d = 1'b1;
        line_d = line_q + 2'd1;
        if (line_q == 2'd3) begin
          if (changed_q || line_diff) begin
            ptr_d       = lfsr_q[3:0];
            scan_d      = '0;
            init_more_d = 1'b0;
            state_d     = SPAWN;
          end else begin
            state_d = CHECK;
          end
        end
      end
      SPAWN: begin
        if (board_q[ptr_q] == 4'd0) begin
          board_d[ptr_q] = spawn_code;
          if (init_more_q) begin
            init_more_d = 1'b0;
            ptr_d       = lfsr_q[3:0];
            scan_d      = '0;
          end else begin
            state_d = CHECK;
          end
        end else begin
          ptr_d  = ptr_q + 4'd1;
          scan_d = scan_q + 4'd1;
          // A full board cannot occur here in practice; bail out rather than spin.
          if (scan_q == 4'd15) state_d = CHECK;
        end
      end
      CHECK: begin
        if (full && !adj_eq) game_over_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT;
      for (int i = 0; i < 16; i++) board_q[i] <= '0;
      lfsr_q      <= LFSR_SEED;
      score_q     <= '0;
      win_q       <= 1'b0;
      game_over_q <= 1'b0;
      dir_q       <= '0;
      line_q      <= '0;
      ptr_q       <= '0;
      scan_q      <= '0;
      changed_q   <= 1'b0;
      init_more_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      lfsr_q      <= lfsr_d;
      score_q     <= score_d;
      win_q       <= win_d;
      game_over_q <= game_over_d;
      dir_q       <= dir_d;
      line_q      <= line_d;
      ptr_q       <= ptr_d;
      scan_q      <= scan_d;
      changed_q   <= changed_d;
      init_more_q <= init_more_d;
    end
  end

  assign BlockType = board_q[BlockID];
  assign busy      = (state_q != IDLE);
  assign score     = score_q;
  assign win       = win_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_board_engine.sv
// Directed bench for board_engine: hand-computed boards, scores and busy windows.
`timescale 1ns/1ps
module tb_board_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        load_en;
  logic [3:0]  load_id;
  logic [3:0]  load_code;
  logic [3:0]  BlockID;
  logic [3:0]  BlockType;
  logic        busy;
  logic [15:0] score;
  logic        win;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  board_engine dut (
    .clk(clk), .rst(rst), .move_valid(move_valid), .move_dir(move_dir),
    .load_en(load_en), .load_id(load_id), .load_code(load_code),
    .BlockID(BlockID), .BlockType(BlockType), .busy(busy), .score(score),
    .win(win), .game_over(game_over)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic read_board(output logic [63:0] b);
    b = '0;
    for (int i = 0; i < 16; i++) begin
      BlockID = 4'(i);
      #0.1;
      b[i*4 +: 4] = BlockType;
    end
  endtask

  task automatic load_all(input logic [63:0] b);
    for (int i = 0; i < 16; i++) begin
      load_en   = 1'b1;
      load_id   = 4'(i);
      load_code = b[i*4 +: 4];
      step;
    end
    load_en = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 60) begin
      cyc++;
      step;
    end
  endtask

  task automatic do_move(input logic [1:0] d, output int cyc);
    move_valid = 1'b1;
    move_dir   = d;
    step;
    move_valid = 1'b0;
    wait_idle(cyc);
  endtask

  function automatic int nz_count(input logic [63:0] b, input logic [15:0] m);
    int n = 0;
    for (int i = 0; i < 16; i++) if (m[i] && b[i*4 +: 4] != 4'd0) n++;
    return n;
  endfunction

  function automatic logic codes_ok(input logic [63:0] b, input logic [15:0] m);
    logic ok = 1'b1;
    for (int i = 0; i < 16; i++)
      if (m[i] && b[i*4 +: 4] != 4'd0 && b[i*4 +: 4] != 4'd1 && b[i*4 +: 4] != 4'd2) ok = 1'b0;
    return ok;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] b;
    int cyc;
    rst = 1'b0; move_valid = 1'b0; move_dir = 2'd0; load_en = 1'b0;
    load_id = '0; load_code = '0; BlockID = '0;

    // Reset state
    step; step;
    read_board(b);
    check("rst_board", b, 64'h0);
    check("rst_busy", busy, 1);
    check("rst_score", score, 0);
    check("rst_win", win, 0);
    check("rst_go", game_over, 0);
    rst = 1'b1;
    wait_idle(cyc);
    check("init_cycles_le34", (cyc <= 34), 1);
    read_board(b);
    check("init_tiles", nz_count(b, 16'hFFFF), 2);
    check("init_codes", codes_ok(b, 16'hFFFF), 1);
    check("init_score", score, 0);
    check("init_go", game_over, 0);

    // Row of four equal tiles: two merges, one spawn
    load_all(64'h0000_0000_0000_1111);
    do_move(2'd2, cyc);
    check("m1111_busy_range", (cyc >= 6 && cyc <= 21), 1);
    read_board(b);
    check("m1111_row0", b[7:0], 8'h22);
    check("m1111_spawn_count", nz_count(b, 16'hFFFC), 1);
    check("m1111_spawn_code", codes_ok(b, 16'hFFFC), 1);
    check("m1111_score", score, 8);

    // Load and move in the same cycle: load wins, move dropped
    load_en = 1'b1; load_id = 4'd5; load_code = 4'd3;
    move_valid = 1'b1; move_dir = 2'd2;
    step;
    load_en = 1'b0; move_valid = 1'b0;
    check("drop_busy", busy, 0);
    BlockID = 4'd5; #0.1;
    check("drop_load", BlockType, 3);

    // Merged tile must not merge again
    load_all(64'h0000_0000_0000_2101);
    do_move(2'd2, cyc);
    read_board(b);
    check("m2101_row0", b[7:0], 8'h22);
    check("m2101_score", score, 12);

    // Unmovable row: no change, no spawn, exact busy window
    load_all(64'h0000_0000_0000_4321);
    do_move(2'd2, cyc);
    check("m4321_busy", cyc, 5);
    read_board(b);
    check("m4321_board", b, 64'h0000_0000_0000_4321);
    check("m4321_score", score, 12);
    check("m4321_go", game_over, 0);

    // Up: column 0 bottom-up [1,1,2,0] -> top-down [2,2,0,0]
    load_all(64'h0000_0002_0001_0001);
    do_move(2'd0, cyc);
    read_board(b);
    check("up_id12", b[51:48], 2);
    check("up_id8", b[35:32], 2);
    check("up_score", score, 16);

    // Down: column 0 bottom-up [3,3,3,0] -> [4,3,0,0]
    load_all(64'h0000_0003_0003_0003);
    do_move(2'd1, cyc);
    read_board(b);
    check("down_id0", b[3:0], 4);
    check("down_id4", b[19:16], 3);
    check("down_score", score, 32);

    // Right: row 1 [0,2,0,2] -> id7 = 3
    load_all(64'h0000_0000_2020_0000);
    do_move(2'd3, cyc);
    read_board(b);
    check("right_id7", b[31:28], 3);
    check("right_score", score, 40);
    check("right_win", win, 0);

    // Fresh game for the win test
    rst = 1'b0; step; rst = 1'b1;
    wait_idle(cyc);
    check("reinit_score", score, 0);
    load_all(64'h0000_0000_0000_00AA);
    do_move(2'd2, cyc);
    read_board(b);
    check("win_id0", b[3:0], 11);
    check("win_flag", win, 1);
    check("win_score", score, 16'd2048);

    // Code 15 saturates, score saturates
    load_all(64'h0000_0000_0000_FFFF);
    do_move(2'd2, cyc);
    read_board(b);
    check("sat_row0", b[7:0], 8'hFF);
    check("sat_score", score, 16'hFFFF);
    check("sat_win", win, 1);

    // Reset during LINE aborts the move
    load_all(64'h0000_0000_0000_1111);
    move_valid = 1'b1; move_dir = 2'd2;
    step;
    move_valid = 1'b0;
    step;
    rst = 1'b0;
    #0.5;
    read_board(b);
    check("midrst_board", b, 64'h0);
    check("midrst_score", score, 0);
    check("midrst_win", win, 0);
    step;
    rst = 1'b1;
    wait_idle(cyc);
    check("midrst_init_cycles", (cyc <= 34), 1);
    read_board(b);
    check("midrst_tiles", nz_count(b, 16'hFFFF), 2);
    check("midrst_codes", codes_ok(b, 16'hFFFF), 1);

    // Checkerboard: no legal move -> game over, further moves ignored
    load_all(64'h1212_2121_1212_2121);
    check("chk_go_before", game_over, 0);
    do_move(2'd0, cyc);
    check("chk_busy", cyc, 5);
    check("chk_go", game_over, 1);
    move_valid = 1'b1; move_dir = 2'd2;
    step;
    move_valid = 1'b0;
    check("chk_ignored_busy", busy, 0);
    step;
    read_board(b);
    check("chk_board", b, 64'h1212_2121_1212_2121);
    check("chk_go_sticky", game_over, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_engine.md
Name: board_engine

Overview:
- Upstream neighbour of the VGA display stage. Holds the 4x4 game board as 4-bit exponent codes and serves the display's combinational tile lookup: BlockID in, BlockType out.
- Executes slide/merge moves one line per cycle, then spawns a new tile from a free-running LFSR.
- Reports score, win and game-over to the top level.

Parameters:
- LFSR_SEED, 16'hACE1, initial LFSR state; must be nonzero.
- WIN_CODE, 11, merge result code (11 = 2048) that sets win.
- FOUR_PROB_MASK, 4'hF, a spawned tile is code 2 when (lfsr[7:4] & mask) == 0, else code 1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- move_valid, input, 1, single-cycle move request.
- move_dir, input, 2, 0=up (toward row 3), 1=down, 2=left (toward col 0), 3=right.
- load_en, input, 1, debug/bench cell write.
- load_id, input, 4, cell written by load_en.
- load_code, input, 4, code written by load_en.
- BlockID, input, 4, display read address; id = 4*row+col, row 0 bottom, col 0 left.
- BlockType, output, 4, board[BlockID], combinational, no latency.
- busy, output, 1, high whenever state != IDLE.
- score, output, 16, accumulated merge value, saturating.
- win, output, 1, sticky win flag.
- game_over, output, 1, sticky no-legal-move flag.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst).
- Reset: all 16 cells = 0, score = 0, win = 0, game_over = 0, lfsr = LFSR_SEED, state = INIT.
- Reset asserted mid-move aborts the move with no partial update surviving.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every cycle outside reset.
- INIT: runs SPAWN twice (spawn counter), then CHECK, then IDLE.

States: INIT, IDLE, LINE, SPAWN, CHECK.
- IDLE, priority order:
  - load_en: writes board[load_id] <= load_code. Score and flags are unchanged. A move_valid in the same cycle is dropped.
  - move_valid with game_over = 0: latch move_dir, clear the changed flag, line index = 0, go to LINE.
  - move_valid with game_over = 1: ignored.
- load_en and move_valid are ignored while busy.
- LINE, one line per cycle, 4 cycles (index 0..3):
  - Read 4 cells ordered from the destination edge: e0 (at the edge) .. e3.
  - Compact the nonzero cells toward e0.
  - Scan pairs from e0 outward. Equal nonzero neighbours merge once: result code+1, saturating at 15. The merged tile does not merge again.
  - Zero-fill the remaining cells and write the line back.
  - Each merge adds 1<<result to score, saturating at 16'hFFFF. When result >= WIN_CODE, set win.
  - Set changed if any cell of the line differs.
  - After index 3: go to SPAWN if changed, else go to CHECK.
- SPAWN:
  - On entry, ptr = lfsr[3:0]. Each cycle, test board[ptr].
  - If empty: write the spawn code and leave (to CHECK, or to the next INIT spawn).
  - Else: ptr = ptr+1 mod 16, scanning at most 16 cycles.
  - An empty cell is guaranteed after a changed move or during INIT.
- CHECK, 1 cycle:
  - Set game_over when no cell is 0 and no horizontally or vertically adjacent pair is equal.
  - Then go to IDLE.
- Timing:
  - Move accepted at cycle T: busy is high from T+1.
  - Unchanged move: lines at T+1..T+4, CHECK at T+5, busy low at T+6.
  - Changed move: adds 1..16 SPAWN cycles.
- BlockType reflects board writes from the cycle after the write. Mid-move it shows partial boards, which the display tolerates.

Test Plan:
- Reset with LFSR_SEED=16'hACE1, then release: within 34 cycles busy = 0, exactly two nonzero cells each of code 1 or 2, score = 0, win = 0, game_over = 0.
- Load all 16 cells: row0 = [1,1,1,1] (ids 0..3), rest 0; move left -> row0 cols 0,1 = [2,2], score = 8, exactly one extra tile in the 14 empty cells, busy high for 6..21 cycles.
- Load row0 = [1,0,1,2], rest 0; move left -> row0 = [2,2,0,0] (not [3,0,0,0]), score = 4.
- Load row0 = [1,2,3,4], rest 0; move left -> board unchanged, no spawn, busy high exactly 5 cycles, score unchanged.
- Load a full checkerboard of codes 1/2; move up -> game_over = 1 after CHECK. A further move_valid leaves busy = 0 and the board is unchanged.
- Load ids 0,1 = 10, rest 0; move left -> id0 = 11, win = 1, score = 2048. Assert rst during a later LINE cycle -> all cells 0, then the INIT spawn sequence runs.
